retire_trace_buffer: RTL and testbench

Buffers retired-instruction records from the core's writeback stage and presents them, in order, to the simulation trace printer that formats each record as assembly text. It sits directly upstream of that printer. It decouples the core from a consumer that may stall, tags every retirement with a sequence number, and counts records dropped on overflow. It also detects a retired `wfi` (32'h10500073) so the testbench can end simulation once the trace has drained.

---
 rtl/retire_trace_buffer.sv | 93 +++++++++
 tb/tb_retire_trace_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Retired-instruction trace FIFO between the core writeback stage and the trace printer.
// Tags each retirement with a sequence number, counts overflow drops and flags a drained wfi.
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     retire_valid_i,
  input  logic [31:0]              retire_pc_i,
  input  logic [31:0]              retire_instr_i,
  input  logic [4:0]               retire_rd_i,
  input  logic [31:0]              retire_rd_data_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [31:0]              trace_rd_data_o,
  output logic [4:0]               trace_rd_o,
  output logic [31:0]              trace_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              dropped_o,
  output logic                     halted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] WFI_INSTR = 32'h10500073;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [31:0]  seq;
  logic         wfi_seen;
  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  logic         drop;

  logic [31:0]  pc_mem      [DEPTH];
  logic [31:0]  instr_mem   [DEPTH];
  logic [31:0]  rd_data_mem [DEPTH];
  logic [4:0]   rd_mem      [DEPTH];
  logic [31:0]  seq_mem     [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop   = !empty && trace_ready_i;
  assign push  = retire_valid_i && (!full || pop);
  assign drop  = retire_valid_i && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      seq       <= '0;
      dropped_o <= '0;
      wfi_seen  <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (pop)
        rptr <= rptr + PTR_ONE;
      if (retire_valid_i)
        seq <= seq + 32'd1;
      if (drop && (dropped_o != 16'hFFFF))
        dropped_o <= dropped_o + 16'd1;
      if (retire_valid_i && (retire_instr_i == WFI_INSTR))
        wfi_seen <= 1'b1;
    end
  end

  // Record storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr[AW-1:0]]      <= retire_pc_i;
      instr_mem[wptr[AW-1:0]]   <= retire_instr_i;
      rd_mem[wptr[AW-1:0]]      <= retire_rd_i;
      rd_data_mem[wptr[AW-1:0]] <= retire_rd_data_i;
      seq_mem[wptr[AW-1:0]]     <= seq;
    end
  end

  assign trace_valid_o   = !empty;
  assign trace_pc_o      = pc_mem[rptr[AW-1:0]];
  assign trace_instr_o   = instr_mem[rptr[AW-1:0]];
  assign trace_rd_o      = rd_mem[rptr[AW-1:0]];
  assign trace_rd_data_o = rd_data_mem[rptr[AW-1:0]];
  // Masked while empty so the sequence output reads 0 straight out of reset.
  assign trace_seq_o     = empty ? 32'd0 : seq_mem[rptr[AW-1:0]];
  assign count_o         = wptr - rptr;
  assign halted_o        = wfi_seen && empty;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized scoreboard bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] WFI_INSTR  = 32'h10500073;
  localparam logic [31:0] ADDI_INSTR = 32'h00100093;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] seq;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        retire_valid_i;
  logic [31:0] retire_pc_i;
  logic [31:0] retire_instr_i;
  logic [4:0]  retire_rd_i;
  logic [31:0] retire_rd_data_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic [31:0] trace_rd_data_o;
  logic [4:0]  trace_rd_o;
  logic [31:0] trace_seq_o;
  logic [3:0]  count_o;
  logic [15:0] dropped_o;
  logic        halted_o;

  rec_t        exp_q[$];
  logic [31:0] m_seq;
  int          m_dropped;
  logic        m_wfi;
  int          checks;
  int          passes;
  int          saved_dropped;

  retire_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .retire_valid_i   (retire_valid_i),
    .retire_pc_i      (retire_pc_i),
    .retire_instr_i   (retire_instr_i),
    .retire_rd_i      (retire_rd_i),
    .retire_rd_data_i (retire_rd_data_i),
    .trace_valid_o    (trace_valid_o),
    .trace_ready_i    (trace_ready_i),
    .trace_pc_o       (trace_pc_o),
    .trace_instr_o    (trace_instr_o),
    .trace_rd_data_o  (trace_rd_data_o),
    .trace_rd_o       (trace_rd_o),
    .trace_seq_o      (trace_seq_o),
    .count_o          (count_o),
    .dropped_o        (dropped_o),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs (called at posedge+1) and advances the model across the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] rd, input logic [31:0] data, input logic rdy);
    logic will_pop;
    logic will_push;
    rec_t rec;
    retire_valid_i   = v;
    retire_pc_i      = pc;
    retire_instr_i   = instr;
    retire_rd_i      = rd;
    retire_rd_data_i = data;
    trace_ready_i    = rdy;
    will_pop  = (exp_q.size() > 0) && rdy;
    will_push = v && ((exp_q.size() < DEPTH) || will_pop);
    rec = '{pc: pc, instr: instr, rd: rd, rd_data: data, seq: m_seq};
    @(posedge clk);
    if (will_push)
      exp_q.push_back(rec);
    if (v && !will_push && (m_dropped < 65535))
      m_dropped++;
    if (v)
      m_seq = m_seq + 32'd1;
    if (v && (instr == WFI_INSTR))
      m_wfi = 1'b1;
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 32'd0, rdy);
  endtask

  task automatic pushOne(input logic [31:0] pc, input logic rdy);
    applyStimulus(1'b1, pc, $urandom & 32'hEFFFFFFF, 5'($urandom), $urandom, rdy);
  endtask

  task automatic doReset();
    rst              = 1'b1;
    retire_valid_i   = 1'b0;
    trace_ready_i    = 1'b0;
    exp_q.delete();
    m_seq     = 32'd0;
    m_dropped = 0;
    m_wfi     = 1'b0;
    #1;
    checkOutput("rst_halted_async", 32'(halted_o), 32'd0);
    checkOutput("rst_valid_async", 32'(trace_valid_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: samples mid-cycle and pops the scoreboard on every accepted handshake.
  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      checkOutput("rst_valid", 32'(trace_valid_o), 32'd0);
      checkOutput("rst_count", 32'(count_o), 32'd0);
      checkOutput("rst_dropped", 32'(dropped_o), 32'd0);
      checkOutput("rst_halted", 32'(halted_o), 32'd0);
      checkOutput("rst_seq", trace_seq_o, 32'd0);
    end else begin
      checkOutput("valid", 32'(trace_valid_o), 32'(exp_q.size() != 0));
      checkOutput("count", 32'(count_o), 32'(exp_q.size()));
      checkOutput("dropped", 32'(dropped_o), 32'(m_dropped));
      checkOutput("halted", 32'(halted_o), 32'(m_wfi && (exp_q.size() == 0)));
      if (trace_valid_o && trace_ready_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pc", trace_pc_o, e.pc);
          checkOutput("instr", trace_instr_o, e.instr);
          checkOutput("rd", 32'(trace_rd_o), 32'(e.rd));
          checkOutput("rd_data", trace_rd_data_o, e.rd_data);
          checkOutput("seq", trace_seq_o, e.seq);
        end
      end
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    retire_valid_i = 1'b0;
    retire_pc_i = '0;
    retire_instr_i = '0;
    retire_rd_i = '0;
    retire_rd_data_i = '0;
    trace_ready_i = 1'b0;
    exp_q.delete();
    m_seq = 32'd0;
    m_dropped = 0;
    m_wfi = 1'b0;
    saved_dropped = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(1'b0, 10);

    for (int i = 0; i < 3; i++)
      pushOne(32'(i * 4), 1'b0);
    checkOutput("count_three", 32'(count_o), 32'd3);
    idle(1'b1, 4);
    checkOutput("count_drained", 32'(count_o), 32'd0);

    doReset();
    for (int i = 0; i < 11; i++)
      pushOne(32'(i * 4), 1'b0);
    checkOutput("overflow_count", 32'(count_o), 32'd8);
    checkOutput("overflow_dropped", 32'(dropped_o), 32'd3);
    idle(1'b1, 8);
    pushOne(32'h100, 1'b0);
    checkOutput("seq_after_drops", trace_seq_o, 32'd11);
    idle(1'b1, 2);

    for (int i = 0; i < DEPTH; i++)
      pushOne(32'h200 + 32'(i * 4), 1'b0);
    saved_dropped = 32'(dropped_o);
    for (int i = 0; i < 20; i++)
      pushOne(32'h300 + 32'(i * 4), 1'b1);
    checkOutput("full_stream_count", 32'(count_o), 32'd8);
    checkOutput("full_stream_dropped", 32'(dropped_o), 32'(saved_dropped));
    idle(1'b1, 10);

    doReset();
    applyStimulus(1'b1, 32'h0, ADDI_INSTR, 5'd1, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'h4, WFI_INSTR, 5'd0, 32'd0, 1'b0);
    checkOutput("wfi_count", 32'(count_o), 32'd2);
    checkOutput("wfi_not_halted", 32'(halted_o), 32'd0);
    idle(1'b1, 2);
    checkOutput("wfi_halted", 32'(halted_o), 32'd1);
    doReset();

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom), $urandom,
                    1'($urandom_range(0, 1)));
    idle(1'b1, 10);

    doReset();
    for (int i = 0; i < DEPTH; i++)
      pushOne(32'(i * 4), 1'b0);
    for (int i = 0; i < 65540; i++)
      pushOne(32'h1000, 1'b0);
    checkOutput("dropped_saturated", 32'(dropped_o), 32'h0000FFFF);
    idle(1'b1, 10);
    checkOutput("final_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
